pe_mac_seq: RTL and testbench

Sequencer for the float16 multiply-accumulate processing element in the filter datapath. On `start` it clears the PE accumulator and streams `num_taps` (sample, coefficient) pairs from two synchronous-read memories into the PE. It gates the PE inputs to zero whenever no valid pair is present, captures the final sum, and pulses `done`. Sample addressing is circular, so a FIR delay line can be walked from any base pointer.

---
 rtl/pe_mac_seq.sv | 143 ++++++++++++++
 tb/tb_pe_mac_seq.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_mac_seq.sv
// Sequencer for the float16 MAC processing element: clears the PE, streams
// num_taps (sample, coefficient) pairs from two sync-read memories, captures the sum.
module pe_mac_seq #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH:0]   num_taps,
    input  logic [ADDR_WIDTH-1:0] sample_base,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] sample_addr,
    output logic [ADDR_WIDTH-1:0] coef_addr,
    input  logic [DATA_WIDTH-1:0] sample_rdata,
    input  logic [DATA_WIDTH-1:0] coef_rdata,
    output logic                  pe_clear,
    output logic [DATA_WIDTH-1:0] pe_a,
    output logic [DATA_WIDTH-1:0] pe_b,
    input  logic [DATA_WIDTH-1:0] pe_result
);

    localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] MAX_TAPS = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t                state, state_d;
    logic [CNT_WIDTH-1:0]  k, k_d;
    logic [CNT_WIDTH-1:0]  n_taps, n_taps_d;
    logic [ADDR_WIDTH-1:0] base, base_d;
    logic                  busy_d, done_d, rd_en_d, rd_valid, rd_valid_d, pe_clear_d;
    logic [DATA_WIDTH-1:0] result_d;
    logic [ADDR_WIDTH-1:0] sample_addr_d, coef_addr_d;

    // Operand gating: the PE only sees data in the cycle a read returns.
    assign pe_a = rd_valid ? sample_rdata : '0;
    assign pe_b = rd_valid ? coef_rdata   : '0;

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            k           <= '0;
            n_taps      <= '0;
            base        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            rd_en       <= 1'b0;
            rd_valid    <= 1'b0;
            sample_addr <= '0;
            coef_addr   <= '0;
            pe_clear    <= 1'b1;
        end else begin
            state       <= state_d;
            k           <= k_d;
            n_taps      <= n_taps_d;
            base        <= base_d;
            busy        <= busy_d;
            done        <= done_d;
            result      <= result_d;
            rd_en       <= rd_en_d;
            rd_valid    <= rd_valid_d;
            sample_addr <= sample_addr_d;
            coef_addr   <= coef_addr_d;
            pe_clear    <= pe_clear_d;
        end
    end

    // Next state and next values of the registered outputs.
    always_comb begin
        state_d       = state;
        k_d           = k;
        n_taps_d      = n_taps;
        base_d        = base;
        done_d        = 1'b0;
        result_d      = result;
        rd_en_d       = 1'b0;
        rd_valid_d    = rd_en;
        sample_addr_d = sample_addr;
        coef_addr_d   = coef_addr;
        pe_clear_d    = 1'b0;

        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_d    = CLEAR;
                    n_taps_d   = (num_taps > MAX_TAPS) ? MAX_TAPS : num_taps;
                    base_d     = sample_base;
                    k_d        = '0;
                    pe_clear_d = 1'b1;
                end
            end
            CLEAR, RUN: begin
                // k counts pairs already issued; the read for tap k goes out next cycle
                if (k == n_taps) begin
                    state_d = (state == CLEAR) ? DONE : DRAIN;
                end else begin
                    state_d       = RUN;
                    rd_en_d       = 1'b1;
                    sample_addr_d = base + ADDR_WIDTH'(k);
                    coef_addr_d   = ADDR_WIDTH'(k);
                    k_d           = k + CNT_WIDTH'(1);
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
            DONE: begin
                state_d  = IDLE;
                done_d   = 1'b1;
                result_d = pe_result;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort cancels any active run and leaves the PE cleared.
        if (abort && (state != IDLE)) begin
            state_d    = IDLE;
            rd_en_d    = 1'b0;
            rd_valid_d = 1'b0;
            pe_clear_d = 1'b1;
            done_d     = 1'b0;
            result_d   = result;
        end

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_pe_mac_seq.sv
// Bench for pe_mac_seq: behavioural float16 PE and sync-read memories around the DUT,
// results compared against a direct dot-product model of the requested run.
module tb_pe_mac_seq;

    localparam int DW    = 16;
    localparam int AW    = 6;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          start, abort;
    logic [AW:0]   num_taps;
    logic [AW-1:0] sample_base;
    logic          busy, done, rd_en, pe_clear;
    logic [DW-1:0] result, pe_a, pe_b, pe_result;
    logic [AW-1:0] sample_addr, coef_addr;
    logic [DW-1:0] sample_rdata, coef_rdata;

    logic [DW-1:0] smem [DEPTH];
    logic [DW-1:0] cmem [DEPTH];
    real           acc = 0.0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pe_mac_seq #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .num_taps(num_taps), .sample_base(sample_base),
        .busy(busy), .done(done), .result(result), .rd_en(rd_en),
        .sample_addr(sample_addr), .coef_addr(coef_addr),
        .sample_rdata(sample_rdata), .coef_rdata(coef_rdata),
        .pe_clear(pe_clear), .pe_a(pe_a), .pe_b(pe_b), .pe_result(pe_result)
    );

    function automatic real h2r(input logic [15:0] h);
        real v;
        int  e;
        e = int'(h[14:10]);
        if (e == 0) begin
            v = real'(int'(h[9:0])) / 16777216.0;
        end else begin
            v = real'(1024 + int'(h[9:0]));
            if (e >= 25) repeat (e - 25) v = v * 2.0;
            else         repeat (25 - e) v = v / 2.0;
        end
        return h[15] ? -v : v;
    endfunction

    function automatic logic [15:0] r2h(input real v);
        real  a;
        int   e;
        int   m;
        logic s;
        if (v == 0.0) return 16'h0000;
        s = (v < 0.0);
        a = s ? -v : v;
        e = 15;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0)  begin a = a * 2.0; e--; end
        m = int'((a - 1.0) * 1024.0);
        return {s, 5'(e), 10'(m)};
    endfunction

    // Memories return junk when not read so ungated operands would corrupt the sum.
    always @(posedge clk) begin
        sample_rdata <= rd_en ? smem[sample_addr] : r2h(real'($urandom_range(1, 7)));
        coef_rdata   <= rd_en ? cmem[coef_addr]   : r2h(real'($urandom_range(1, 7)));
    end

    always @(posedge clk) begin
        if (pe_clear) acc <= 0.0;
        else          acc <= acc + h2r(pe_a) * h2r(pe_b);
    end
    assign pe_result = r2h(acc);

    function automatic logic [15:0] model_sum(input int n, input int base);
        real s;
        s = 0.0;
        for (int k = 0; k < n; k++)
            s = s + h2r(smem[(base + k) % DEPTH]) * h2r(cmem[k]);
        return r2h(s);
    endfunction

    task automatic fill_random();
        for (int i = 0; i < DEPTH; i++) begin
            smem[i] = r2h(real'($urandom_range(0, 6)) - 3.0);
            cmem[i] = r2h(real'($urandom_range(0, 6)) - 3.0);
        end
    endtask

    task automatic fill_const(input logic [15:0] s, input logic [15:0] c);
        for (int i = 0; i < DEPTH; i++) begin
            smem[i] = s;
            cmem[i] = c;
        end
    endtask

    // Starts a run at the current negedge, follows it cycle by cycle and checks it.
    task automatic run_and_verify(input int n_req, input int base, input bit pulse_start);
        int n, lat, idx, done_cycle;
        int busy_bad, clr_bad, gate_bad, addr_bad;
        logic [15:0] exp_res;
        n = (n_req > DEPTH) ? DEPTH : n_req;
        lat = (n == 0) ? 3 : n + 4;
        exp_res = model_sum(n, base);
        idx = 0; done_cycle = -1;
        busy_bad = 0; clr_bad = 0; gate_bad = 0; addr_bad = 0;
        abort = 1'b0;
        start = 1'b1;
        num_taps = 7'(n_req);
        sample_base = 6'(base);
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= lat + 4; c++) begin
            if (busy !== (c < lat)) busy_bad++;
            if (pe_clear !== (c == 1)) clr_bad++;
            if ((c < 3 || c > n + 2) && (pe_a !== 16'h0 || pe_b !== 16'h0)) gate_bad++;
            if (rd_en === 1'b1) begin
                if (c != 2 + idx || sample_addr !== 6'((base + idx) % DEPTH) || coef_addr !== 6'(idx))
                    addr_bad++;
                idx++;
            end
            if (done === 1'b1) begin
                done_cycle = c;
                break;
            end
            if (pulse_start && c == 3) begin
                start = 1'b1;
                num_taps = 7'd5;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (done_cycle != lat) begin
            errors++;
            $display("FAIL latency n=%0d base=%0d: done in cycle %0d, expected %0d", n, base, done_cycle, lat);
        end
        checks++;
        if (result !== exp_res) begin
            errors++;
            $display("FAIL result n=%0d base=%0d: got %h, expected %h", n, base, result, exp_res);
        end
        checks++;
        if (busy_bad != 0) begin
            errors++;
            $display("FAIL busy_window n=%0d: %0d wrong cycles, expected 0", n, busy_bad);
        end
        checks++;
        if (clr_bad != 0) begin
            errors++;
            $display("FAIL pe_clear_pulse n=%0d: %0d wrong cycles, expected 0", n, clr_bad);
        end
        checks++;
        if (gate_bad != 0) begin
            errors++;
            $display("FAIL operand_gating n=%0d: %0d nonzero cycles outside data window, expected 0", n, gate_bad);
        end
        checks++;
        if (addr_bad != 0 || idx != n) begin
            errors++;
            $display("FAIL read_sequence n=%0d base=%0d: %0d bad reads, %0d reads, expected %0d", n, base, addr_bad, idx, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; num_taps = '0; sample_base = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 16'h0 || rd_en !== 1'b0 ||
            sample_addr !== 6'd0 || coef_addr !== 6'd0 || pe_clear !== 1'b1 || pe_a !== 16'h0) begin
            errors++;
            $display("FAIL reset_values: busy=%b done=%b result=%h rd_en=%b sa=%0d ca=%0d pe_clear=%b, expected 0 0 0000 0 0 0 1",
                     busy, done, result, rd_en, sample_addr, coef_addr, pe_clear);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (pe_clear !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: pe_clear=%b busy=%b, expected 0 0", pe_clear, busy);
        end
    endtask

    task automatic test_single_tap();
        fill_const(16'h0000, 16'h0000);
        smem[0] = 16'h3C00;
        cmem[0] = 16'h4000;
        run_and_verify(1, 0, 1'b0);
        checks++;
        if (result !== 16'h4000) begin
            errors++;
            $display("FAIL single_tap: result %h, expected 4000", result);
        end
    endtask

    task automatic test_four_ones();
        @(negedge clk);
        fill_const(16'h3C00, 16'h3C00);
        run_and_verify(4, 0, 1'b0);
        checks++;
        if (result !== 16'h4400) begin
            errors++;
            $display("FAIL four_ones: result %h, expected 4400", result);
        end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        fill_random();
        run_and_verify(4, 62, 1'b0);
        @(negedge clk);
        run_and_verify(10, 59, 1'b0);
    endtask

    task automatic test_zero_taps();
        logic [15:0] prev;
        @(negedge clk);
        fill_random();
        prev = result;
        run_and_verify(0, 17, 1'b0);
        checks++;
        if (result !== 16'h0000 || prev === 16'h0000) begin
            errors++;
            $display("FAIL zero_taps: result %h (previous %h), expected 0000 after nonzero", result, prev);
        end
    endtask

    task automatic test_random_runs();
        for (int r = 0; r < 6; r++) begin
            @(negedge clk);
            fill_random();
            run_and_verify(int'($urandom_range(1, 64)), int'($urandom_range(0, 63)), 1'b0);
        end
    endtask

    task automatic test_clamp();
        @(negedge clk);
        fill_random();
        run_and_verify(100, 5, 1'b0);
        @(negedge clk);
        run_and_verify(64, 33, 1'b0);
    endtask

    task automatic test_abort();
        logic [15:0] prev;
        int done_seen;
        @(negedge clk);
        fill_random();
        prev = result;
        start = 1'b1; num_taps = 7'd8; sample_base = 6'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || rd_en !== 1'b0 || pe_clear !== 1'b1 || pe_a !== 16'h0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_response: busy=%b rd_en=%b pe_clear=%b pe_a=%h done=%b, expected 0 0 1 0000 0",
                     busy, rd_en, pe_clear, pe_a, done);
        end
        done_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        checks++;
        if (done_seen != 0 || result !== prev) begin
            errors++;
            $display("FAIL abort_quiet: %0d active cycles, result %h, expected 0 and %h", done_seen, result, prev);
        end
        fill_const(16'h3C00, 16'h3C00);
        run_and_verify(2, 0, 1'b0);
        checks++;
        if (result !== 16'h4000) begin
            errors++;
            $display("FAIL abort_rerun: result %h, expected 4000", result);
        end
    endtask

    task automatic test_abort_start_idle();
        @(negedge clk);
        start = 1'b1; abort = 1'b1; num_taps = 7'd3;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || pe_clear !== 1'b0) begin
            errors++;
            $display("FAIL abort_beats_start: busy=%b pe_clear=%b, expected 0 0", busy, pe_clear);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rd_en !== 1'b0) begin
            errors++;
            $display("FAIL abort_beats_start_late: busy=%b rd_en=%b, expected 0 0", busy, rd_en);
        end
    endtask

    task automatic test_start_ignored();
        fill_random();
        run_and_verify(12, 40, 1'b1);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        fill_random();
        run_and_verify(7, 60, 1'b0);
        fill_random();
        run_and_verify(9, 1, 1'b0);
        fill_random();
        run_and_verify(0, 0, 1'b0);
        run_and_verify(3, 63, 1'b0);
    endtask

    task automatic test_reset_midrun();
        @(negedge clk);
        fill_random();
        start = 1'b1; num_taps = 7'd16; sample_base = 6'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 16'h0 || rd_en !== 1'b0 ||
            sample_addr !== 6'd0 || coef_addr !== 6'd0 || pe_clear !== 1'b1 || pe_a !== 16'h0) begin
            errors++;
            $display("FAIL reset_midrun: busy=%b done=%b result=%h rd_en=%b sa=%0d ca=%0d pe_clear=%b pe_a=%h, expected reset values",
                     busy, done, result, rd_en, sample_addr, coef_addr, pe_clear, pe_a);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_and_verify(5, 20, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_tap();
        test_four_ones();
        test_wrap();
        test_zero_taps();
        test_random_runs();
        test_clamp();
        test_abort();
        test_abort_start_idle();
        test_start_ignored();
        test_back_to_back();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
